// File: rtl/bforge_apb_regbank.sv
// APB completer register bank: a single FSM with a configurable number of wait states,
// byte-strobed writes, read-only registers sourced from hardware, and per-register write pulses.
module bforge_apb_regbank #(
    parameter int                  ADDR_WIDTH  = 16,
    parameter int                  DATA_WIDTH  = 32,
    parameter int                  NUM_REGS    = 8,
    parameter int                  WAIT_CYCLES = 0,
    parameter logic [NUM_REGS-1:0] RO_MASK     = '0
) (
    input  logic                           pclk,
    input  logic                           presetn,
    input  logic                           psel,
    input  logic                           penable,
    input  logic [ADDR_WIDTH-1:0]          paddr,
    input  logic                           pwrite,
    input  logic [DATA_WIDTH-1:0]          pwdata,
    input  logic [DATA_WIDTH/8-1:0]        pstrb,
    output logic [DATA_WIDTH-1:0]          prdata,
    output logic                           pready,
    output logic                           pslverr,
    output logic [NUM_REGS*DATA_WIDTH-1:0] reg_q,
    input  logic [NUM_REGS*DATA_WIDTH-1:0] hw_rdata,
    output logic [NUM_REGS-1:0]            wr_pulse
);

    localparam int                    STRB_W     = DATA_WIDTH / 8;
    localparam int                    LSB        = $clog2(STRB_W);
    localparam int                    IDX_W      = ADDR_WIDTH + 9;
    localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK = ADDR_WIDTH'(STRB_W - 1);
    localparam logic [3:0]            WAIT_INIT  = 4'(WAIT_CYCLES);

    typedef enum logic {
        IDLE,
        ACCESS
    } state_t;

    state_t                state_q, state_d;
    logic [3:0]            cnt_q, cnt_d;
    logic                  pready_q, pready_d;
    logic                  pslverr_q, pslverr_d;
    logic [DATA_WIDTH-1:0] prdata_q, prdata_d;
    logic [NUM_REGS-1:0]   wr_pulse_q, wr_pulse_d;
    logic [DATA_WIDTH-1:0] regs_q [NUM_REGS];
    logic [DATA_WIDTH-1:0] regs_d [NUM_REGS];

    logic [ADDR_WIDTH-1:0] idx;
    logic                  misaligned;
    logic                  in_range;
    logic                  sel_ro;
    logic [DATA_WIDTH-1:0] sel_rdata;
    logic                  access_err;
    logic                  raise;
    logic                  commit;

    // Address decode; the index is compared in a widened form so NUM_REGS=256 never truncates.
    always_comb begin
        idx        = paddr >> LSB;
        misaligned = |(paddr & ALIGN_MASK);
        in_range   = IDX_W'(idx) < IDX_W'(NUM_REGS);
        sel_ro     = 1'b0;
        sel_rdata  = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (idx == ADDR_WIDTH'(i)) begin
                sel_ro    = RO_MASK[i];
                sel_rdata = RO_MASK[i] ? hw_rdata[i*DATA_WIDTH +: DATA_WIDTH] : regs_q[i];
            end
        end
        access_err = misaligned | ~in_range | (pwrite & sel_ro);
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        pready_d   = 1'b0;
        pslverr_d  = 1'b0;
        prdata_d   = '0;
        wr_pulse_d = '0;
        regs_d     = regs_q;
        raise      = 1'b0;
        commit     = 1'b0;

        case (state_q)
            IDLE: begin
                if (psel && !penable) begin
                    state_d = ACCESS;
                    cnt_d   = WAIT_INIT;
                    raise   = (WAIT_INIT == 4'd0);
                end
            end
            ACCESS: begin
                if (!psel) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else if (pready_q) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                    commit  = pwrite && !pslverr_q;
                end else begin
                    if (cnt_q != 4'd0) begin
                        cnt_d = cnt_q - 4'd1;
                    end
                    raise = (cnt_q <= 4'd1);
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase

        // Response (error, read data, hw_rdata sample) is captured on the edge that raises pready.
        if (raise) begin
            pready_d  = 1'b1;
            pslverr_d = access_err;
            prdata_d  = (!pwrite && !access_err) ? sel_rdata : '0;
        end

        // Write lands on the completing edge; a zero strobe still pulses.
        for (int i = 0; i < NUM_REGS; i++) begin
            if (commit && idx == ADDR_WIDTH'(i)) begin
                wr_pulse_d[i] = 1'b1;
                if (!RO_MASK[i]) begin
                    for (int b = 0; b < STRB_W; b++) begin
                        if (pstrb[b]) begin
                            regs_d[i][b*8 +: 8] = pwdata[b*8 +: 8];
                        end
                    end
                end
            end
        end
    end

    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            pready_q   <= 1'b0;
            pslverr_q  <= 1'b0;
            prdata_q   <= '0;
            wr_pulse_q <= '0;
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            pready_q   <= pready_d;
            pslverr_q  <= pslverr_d;
            prdata_q   <= prdata_d;
            wr_pulse_q <= wr_pulse_d;
            regs_q     <= regs_d;
        end
    end

    assign prdata   = prdata_q;
    assign pready   = pready_q;
    assign pslverr  = pslverr_q;
    assign wr_pulse = wr_pulse_q;

    for (genvar g = 0; g < NUM_REGS; g++) begin : g_flat
        assign reg_q[g*DATA_WIDTH +: DATA_WIDTH] = regs_q[g];
    end

endmodule

// File: tb/tb_bforge_apb_regbank.sv
// Bench for bforge_apb_regbank: two instances (0 and 3 wait states) driven with directed
// and random APB traffic; a scoreboard monitor checks every response against a reference model.
module tb_bforge_apb_regbank;

    localparam logic [7:0] RO = 8'h04;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        logic        wr_ok;
        int          idx;
        logic [31:0] newval;
    } exp_t;

    logic                  pclk;
    logic [1:0]            rstn;
    logic [1:0]            psel, penable, pwrite;
    logic [1:0][15:0]      paddr;
    logic [1:0][31:0]      pwdata;
    logic [1:0][3:0]       pstrb;
    logic [1:0][31:0]      prdata;
    logic [1:0]            pready, pslverr;
    logic [1:0][255:0]     reg_q, hw;
    logic [1:0][7:0]       wr_pulse;

    logic [31:0] mdl    [2][8];
    logic [31:0] shadow [2][8];
    logic [7:0]  pend   [2];
    exp_t        q0[$], q1[$];
    int          checks, errors;

    bforge_apb_regbank #(.ADDR_WIDTH(16), .DATA_WIDTH(32), .NUM_REGS(8), .WAIT_CYCLES(0), .RO_MASK(RO)) u_dut0 (
        .pclk(pclk), .presetn(rstn[0]), .psel(psel[0]), .penable(penable[0]), .paddr(paddr[0]),
        .pwrite(pwrite[0]), .pwdata(pwdata[0]), .pstrb(pstrb[0]), .prdata(prdata[0]), .pready(pready[0]),
        .pslverr(pslverr[0]), .reg_q(reg_q[0]), .hw_rdata(hw[0]), .wr_pulse(wr_pulse[0]));

    bforge_apb_regbank #(.ADDR_WIDTH(16), .DATA_WIDTH(32), .NUM_REGS(8), .WAIT_CYCLES(3), .RO_MASK(RO)) u_dut1 (
        .pclk(pclk), .presetn(rstn[1]), .psel(psel[1]), .penable(penable[1]), .paddr(paddr[1]),
        .pwrite(pwrite[1]), .pwdata(pwdata[1]), .pstrb(pstrb[1]), .prdata(prdata[1]), .pready(pready[1]),
        .pslverr(pslverr[1]), .reg_q(reg_q[1]), .hw_rdata(hw[1]), .wr_pulse(wr_pulse[1]));

    initial begin
        pclk = 1'b0;
        forever #5 pclk = ~pclk;
    end

    function automatic void chk(string nm, logic [255:0] act, logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endfunction

    function automatic int waits(int d);
        return (d == 0) ? 0 : 3;
    endfunction

    function automatic logic [255:0] flat(int d);
        logic [255:0] v;
        for (int i = 0; i < 8; i++) v[i*32 +: 32] = shadow[d][i];
        return v;
    endfunction

    // Scoreboard monitor: samples on the falling edge, away from the active edge.
    always @(negedge pclk) begin
        for (int d = 0; d < 2; d++) begin
            if (rstn[d]) begin
                exp_t e;
                logic ok;
                chk($sformatf("reg_q%0d", d), reg_q[d], flat(d));
                chk($sformatf("wr_pulse%0d", d), 256'(wr_pulse[d]), 256'(pend[d]));
                pend[d] = '0;
                if (pready[d]) begin
                    ok = 1'b0;
                    if (d == 0 && q0.size() > 0) begin e = q0.pop_front(); ok = 1'b1; end
                    if (d == 1 && q1.size() > 0) begin e = q1.pop_front(); ok = 1'b1; end
                    chk($sformatf("resp_expected%0d", d), 256'(ok), 256'(1));
                    if (ok) begin
                        chk($sformatf("prdata%0d", d), 256'(prdata[d]), 256'(e.rdata));
                        chk($sformatf("pslverr%0d", d), 256'(pslverr[d]), 256'(e.err));
                        if (e.wr_ok) begin
                            shadow[d][e.idx] = e.newval;
                            pend[d] = 8'(1 << e.idx);
                        end
                    end
                end else begin
                    chk($sformatf("quiet%0d", d), 256'({prdata[d], pslverr[d]}), 256'(0));
                end
            end
        end
    end

    task automatic idle(input int d);
        psel[d] = 1'b0;
        penable[d] = 1'b0;
        @(posedge pclk); #1;
    endtask

    // Issues one transfer and returns one tick after its completing edge with psel still high.
    task automatic xfer(input int d, input logic [15:0] addr, input logic wr,
                        input logic [31:0] wdata, input logic [3:0] strb);
        exp_t e;
        int n;
        int ix;
        logic [31:0] mask;
        ix = int'(addr) / 4;
        e.err = (addr % 4 != 0) || (ix >= 8) || (wr && RO[ix % 8]);
        e.wr_ok = wr && !e.err;
        e.idx = ix % 8;
        e.rdata = '0;
        e.newval = '0;
        if (!wr && !e.err) e.rdata = RO[ix] ? hw[d][ix*32 +: 32] : mdl[d][ix];
        if (e.wr_ok) begin
            mask = '0;
            for (int b = 0; b < 4; b++) if (strb[b]) mask = mask | (32'hFF << (8 * b));
            e.newval = (mdl[d][ix] & ~mask) | (wdata & mask);
            mdl[d][ix] = e.newval;
        end
        if (d == 0) q0.push_back(e); else q1.push_back(e);

        psel[d] = 1'b1; penable[d] = 1'b0; paddr[d] = addr;
        pwrite[d] = wr; pwdata[d] = wdata; pstrb[d] = strb;
        @(posedge pclk); #1;
        penable[d] = 1'b1;
        n = 0;
        while (!pready[d] && n < 40) begin
            @(posedge pclk); #1;
            n++;
        end
        chk($sformatf("latency%0d", d), 256'(n), 256'(waits(d)));
        if (n >= 40) begin
            psel[d] = 1'b0;
            penable[d] = 1'b0;
        end else begin
            @(posedge pclk); #1;
            penable[d] = 1'b0;
        end
    endtask

    task automatic reset_model(input int d);
        for (int i = 0; i < 8; i++) begin
            mdl[d][i] = '0;
            shadow[d][i] = '0;
        end
        pend[d] = '0;
    endtask

    function automatic logic [15:0] rand_addr();
        int r;
        r = $urandom_range(0, 9);
        if (r <= 6) return 16'(4 * $urandom_range(0, 7));
        if (r == 7) return 16'(32 + 4 * $urandom_range(0, 15));
        if (r == 8) return 16'(4 * $urandom_range(0, 7) + $urandom_range(1, 3));
        return 16'($urandom);
    endfunction

    initial begin
        checks = 0;
        errors = 0;
        rstn = 2'b00;
        psel = '0; penable = '0; pwrite = '0; paddr = '0; pwdata = '0; pstrb = '0;
        hw[0] = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
        hw[1] = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
        for (int d = 0; d < 2; d++) reset_model(d);

        #22;
        for (int d = 0; d < 2; d++) begin
            chk($sformatf("rst_pready%0d", d), 256'(pready[d]), 256'(0));
            chk($sformatf("rst_pslverr%0d", d), 256'(pslverr[d]), 256'(0));
            chk($sformatf("rst_prdata%0d", d), 256'(prdata[d]), 256'(0));
            chk($sformatf("rst_wr_pulse%0d", d), 256'(wr_pulse[d]), 256'(0));
            chk($sformatf("rst_reg_q%0d", d), reg_q[d], 256'(0));
        end
        #10 rstn = 2'b11;
        @(posedge pclk); #1;

        // Zero-wait instance: full write, partial write, readback, errors, read-only register.
        xfer(0, 16'h0004, 1'b1, 32'hDEADBEEF, 4'hF);
        xfer(0, 16'h0004, 1'b1, 32'h0000AB00, 4'h2);
        xfer(0, 16'h0004, 1'b0, 32'h0, 4'h0);
        idle(0);
        chk("partial_write_reg1", 256'(reg_q[0][63:32]), 256'(32'hDEADABEF));
        xfer(0, 16'h0020, 1'b0, 32'h0, 4'hF);
        xfer(0, 16'h0005, 1'b1, 32'h11223344, 4'hF);
        xfer(0, 16'h0008, 1'b1, 32'h55667788, 4'hF);
        idle(0);
        hw[0][95:64] = 32'h12345678;
        xfer(0, 16'h0008, 1'b0, 32'h0, 4'hA);
        xfer(0, 16'h000C, 1'b1, 32'hFFFFFFFF, 4'h0);
        idle(0);

        // Three-wait instance: write, waited read, abort, reset during a wait state.
        xfer(1, 16'h0000, 1'b1, 32'hA5A5C3C3, 4'hF);
        xfer(1, 16'h0000, 1'b0, 32'h0, 4'h0);
        idle(1);
        psel[1] = 1'b1; penable[1] = 1'b0; paddr[1] = 16'h0010; pwrite[1] = 1'b1;
        pwdata[1] = 32'h0BADF00D; pstrb[1] = 4'hF;
        @(posedge pclk); #1;
        penable[1] = 1'b1;
        @(posedge pclk); #1;
        idle(1);
        idle(1);
        xfer(1, 16'h0010, 1'b0, 32'h0, 4'h0);
        idle(1);
        psel[1] = 1'b1; penable[1] = 1'b0; paddr[1] = 16'h000C; pwrite[1] = 1'b1;
        pwdata[1] = 32'hCAFEF00D; pstrb[1] = 4'hF;
        @(posedge pclk); #1;
        penable[1] = 1'b1;
        @(posedge pclk); #2;
        rstn[1] = 1'b0;
        reset_model(1);
        #1;
        chk("midrst_pready", 256'(pready[1]), 256'(0));
        chk("midrst_pslverr", 256'(pslverr[1]), 256'(0));
        chk("midrst_prdata", 256'(prdata[1]), 256'(0));
        chk("midrst_wr_pulse", 256'(wr_pulse[1]), 256'(0));
        chk("midrst_reg_q", reg_q[1], 256'(0));
        psel[1] = 1'b0; penable[1] = 1'b0;
        @(posedge pclk); @(posedge pclk); #3;
        rstn[1] = 1'b1;
        xfer(1, 16'h000C, 1'b0, 32'h0, 4'h0);
        idle(1);
        chk("after_rst_reg3", 256'(reg_q[1][127:96]), 256'(0));

        // Random traffic on both instances, with random back-to-back transfers.
        for (int d = 0; d < 2; d++) begin
            for (int k = 0; k < 80; k++) begin
                if ($urandom_range(0, 3) == 0)
                    hw[d] = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
                xfer(d, rand_addr(), 1'($urandom), $urandom, 4'($urandom));
                if ($urandom_range(0, 1) == 0) idle(d);
            end
            idle(d);
        end

        repeat (5) @(posedge pclk);
        #1;
        chk("queue0_drained", 256'(q0.size()), 256'(0));
        chk("queue1_drained", 256'(q1.size()), 256'(0));
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
